// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants, the decoded control bundle and
// the operand-use decode needed by hazard detection.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // rs1 is read by everything except the upper-immediate forms and JAL
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle stall, unless EX is redirecting.
module hazard_unit
    import rv_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use_stall
);

    logic [1:0] src_used;
    logic [1:0] src_match;
    logic [4:0] src_idx [2];

    assign src_used[0] = uses_rs1(id_opcode);
    assign src_used[1] = uses_rs2(id_opcode);
    assign src_idx[0]  = id_rs1;
    assign src_idx[1]  = id_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_idx[gi] == ex_rd);
        end
    endgenerate

    // x0 is never a real destination, so a load to x0 cannot create a hazard
    assign load_use_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                            && (|src_match) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush handling and
// a free-running count of inserted bubbles.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic            id_alu_src,
    input  logic            id_mem_to_reg,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic [1:0]      id_alu_op,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic            flush,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic            ex_alu_src,
    output logic            ex_mem_to_reg,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic [1:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_b5,
    output logic [CNT_W-1:0] bubble_count
);

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_reg;
    logic             valid_reg;
    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  rs1_data_reg;
    logic [XLEN-1:0]  rs2_data_reg;
    logic [XLEN-1:0]  imm_reg;
    logic [4:0]       rs1_reg;
    logic [4:0]       rs2_reg;
    logic [4:0]       rd_reg;
    logic [2:0]       funct3_reg;
    logic             funct7_b5_reg;
    logic [CNT_W-1:0] bubble_count_reg;
    logic             insert_bubble;

    assign id_ctrl = '{
        alu_src:    id_alu_src,
        mem_to_reg: id_mem_to_reg,
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        branch:     id_branch,
        alu_op:     id_alu_op
    };

    hazard_unit u_hazard (
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .flush          (flush),
        .ex_valid       (valid_reg),
        .ex_mem_read    (ctrl_reg.mem_read),
        .ex_rd          (rd_reg),
        .load_use_stall (load_use_stall)
    );

    // The stall term is already masked by flush, so this is true for exactly
    // one counted bubble even when both causes coincide.
    assign insert_bubble = flush || load_use_stall;

    always_ff @(posedge clk) begin
        if (rst || insert_bubble) begin
            valid_reg     <= 1'b0;
            ctrl_reg      <= CTRL_NOP;
            pc_reg        <= '0;
            rs1_data_reg  <= '0;
            rs2_data_reg  <= '0;
            imm_reg       <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            funct3_reg    <= '0;
            funct7_b5_reg <= 1'b0;
        end else begin
            valid_reg     <= id_valid;
            // An empty ID slot must never carry live control into EX
            ctrl_reg      <= id_valid ? id_ctrl : CTRL_NOP;
            pc_reg        <= id_pc;
            rs1_data_reg  <= id_rs1_data;
            rs2_data_reg  <= id_rs2_data;
            imm_reg       <= id_imm;
            rs1_reg       <= id_rs1;
            rs2_reg       <= id_rs2;
            rd_reg        <= id_rd;
            funct3_reg    <= id_funct3;
            funct7_b5_reg <= id_funct7_b5;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count_reg <= '0;
        end else if (insert_bubble) begin
            bubble_count_reg <= bubble_count_reg + CNT_W'(1);
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_alu_src    = ctrl_reg.alu_src;
    assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
    assign ex_reg_write  = ctrl_reg.reg_write;
    assign ex_mem_read   = ctrl_reg.mem_read;
    assign ex_mem_write  = ctrl_reg.mem_write;
    assign ex_branch     = ctrl_reg.branch;
    assign ex_alu_op     = ctrl_reg.alu_op;
    assign ex_pc         = pc_reg;
    assign ex_rs1_data   = rs1_data_reg;
    assign ex_rs2_data   = rs2_data_reg;
    assign ex_imm        = imm_reg;
    assign ex_rs1        = rs1_reg;
    assign ex_rs2        = rs2_reg;
    assign ex_rd         = rd_reg;
    assign ex_funct3     = funct3_reg;
    assign ex_funct7_b5  = funct7_b5_reg;
    assign bubble_count  = bubble_count_reg;

endmodule
